// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller in ID: load-use stalls, branch flushes and
// whole-pipeline freeze while data memory is busy, plus a stall-cycle counter.
module hazard_unit_mc #(
   parameter int REG_AW     = 5,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_branch_taken,
   input  logic              mem_access,
   input  logic              dmem_ready,
   output logic              pc_write_en,
   output logic              if_id_write_en,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic              pipe_freeze,
   output logic              busy,
   output logic [CNT_W-1:0]  stall_cycles
);

   typedef enum logic {IDLE, LWAIT} stateT;

   localparam logic [1:0] CNT_LOAD = 2'(LOAD_STALL - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   stateT      state;
   logic [1:0] cnt;
   logic       hazard;
   logic       freeze;
   logic       stallNow;
   logic       countEn;

   assign hazard = ex_mem_read && (ex_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) ||
                    (id_rs2_used && (id_rs2 == ex_rd)));
   assign freeze = mem_access && !dmem_ready;

   // Controls are combinational so the first stall and any freeze take
   // effect in the cycle they are seen; reset forces the default set.
   always_comb begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_bubble   = 1'b0;
      pipe_freeze    = 1'b0;
      stallNow       = 1'b0;
      if (!rst_n) begin
         pc_write_en = 1'b1;
      end else if (freeze) begin
         pipe_freeze    = 1'b1;
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if ((state == LWAIT) || hazard) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_bubble   = 1'b1;
         stallNow       = 1'b1;
      end
   end

   assign countEn = rst_n && (freeze || stallNow);
   assign busy    = rst_n && (state == LWAIT);

   // A frozen cycle holds the FSM entirely, so freezes only ever extend LWAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         stall_cycles <= '0;
      end else begin
         if (countEn && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + 1'b1;
         if (!freeze) begin
            if (ex_branch_taken) begin
               state <= IDLE;
               cnt   <= '0;
            end else if (state == IDLE) begin
               if (hazard && (LOAD_STALL > 1)) begin
                  state <= LWAIT;
                  cnt   <= CNT_LOAD;
               end
            end else if (cnt == 2'd1) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt - 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: three instances (single-cycle load, three-cycle
// load, narrow counter) share one stimulus stream; each check targets one instance.
module tb_hazard_unit_mc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] idRs1 = '0, idRs2 = '0, exRd = '0;
   logic       idRs1Used = 1'b0, idRs2Used = 1'b0;
   logic       exMemRead = 1'b0, exBranchTaken = 1'b0;
   logic       memAccess = 1'b0, dmemReady = 1'b1;

   logic pc1, ifid1, flush1, bubble1, frz1, busy1;
   logic pc3, ifid3, flush3, bubble3, frz3, busy3;
   logic pc4, ifid4, flush4, bubble4, frz4, busy4;
   logic [15:0] cnt1, cnt3;
   logic [3:0]  cnt4;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_rs1(idRs1), .id_rs2(idRs2),
      .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used), .ex_rd(exRd),
      .ex_mem_read(exMemRead), .ex_branch_taken(exBranchTaken),
      .mem_access(memAccess), .dmem_ready(dmemReady),
      .pc_write_en(pc1), .if_id_write_en(ifid1), .if_id_flush(flush1),
      .id_ex_bubble(bubble1), .pipe_freeze(frz1), .busy(busy1),
      .stall_cycles(cnt1));

   hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst_n(rst_n), .id_rs1(idRs1), .id_rs2(idRs2),
      .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used), .ex_rd(exRd),
      .ex_mem_read(exMemRead), .ex_branch_taken(exBranchTaken),
      .mem_access(memAccess), .dmem_ready(dmemReady),
      .pc_write_en(pc3), .if_id_write_en(ifid3), .if_id_flush(flush3),
      .id_ex_bubble(bubble3), .pipe_freeze(frz3), .busy(busy3),
      .stall_cycles(cnt3));

   hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .id_rs1(idRs1), .id_rs2(idRs2),
      .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used), .ex_rd(exRd),
      .ex_mem_read(exMemRead), .ex_branch_taken(exBranchTaken),
      .mem_access(memAccess), .dmem_ready(dmemReady),
      .pc_write_en(pc4), .if_id_write_en(ifid4), .if_id_flush(flush4),
      .id_ex_bubble(bubble4), .pipe_freeze(frz4), .busy(busy4),
      .stall_cycles(cnt4));

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs just after the rising edge, returns at the falling edge.
   task automatic applyStimulus(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic memRead, input logic branch, input logic frz);
      @(posedge clk);
      #1;
      exRd = rd; idRs1 = rs1; idRs2 = rs2;
      idRs1Used = u1; idRs2Used = u2;
      exMemRead = memRead; exBranchTaken = branch;
      memAccess = frz; dmemReady = !frz;
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic resetAll();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exRd = '0; idRs1 = '0; idRs2 = '0; idRs1Used = 1'b0; idRs2Used = 1'b0;
      exMemRead = 1'b0; exBranchTaken = 1'b0; memAccess = 1'b0; dmemReady = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      $display("[TB] hazard_unit_mc directed test");
      #2;
      checkOutput("rst_pc", 32'(pc3), 32'd1);
      checkOutput("rst_busy", 32'(busy3), 32'd0);
      checkOutput("rst_cnt", 32'(cnt3), 32'd0);
      resetAll();

      // single-cycle load: x5 used via rs2
      applyStimulus(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("ls1_pc", 32'(pc1), 32'd0);
      checkOutput("ls1_ifid", 32'(ifid1), 32'd0);
      checkOutput("ls1_bubble", 32'(bubble1), 32'd1);
      checkOutput("ls1_busy", 32'(busy1), 32'd0);
      idleCycle();
      checkOutput("ls1_after_pc", 32'(pc1), 32'd1);
      checkOutput("ls1_after_bubble", 32'(bubble1), 32'd0);
      checkOutput("ls1_cnt", 32'(cnt1), 32'd1);

      // three-cycle load: x7 used via rs1
      resetAll();
      applyStimulus(5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("ls3_c1_pc", 32'(pc3), 32'd0);
      checkOutput("ls3_c1_busy", 32'(busy3), 32'd0);
      for (int c = 2; c <= 3; c++) begin
         idleCycle();
         checkOutput($sformatf("ls3_c%0d_bubble", c), 32'(bubble3), 32'd1);
         checkOutput($sformatf("ls3_c%0d_busy", c), 32'(busy3), 32'd1);
      end
      idleCycle();
      checkOutput("ls3_done_pc", 32'(pc3), 32'd1);
      checkOutput("ls3_done_busy", 32'(busy3), 32'd0);
      checkOutput("ls3_cnt", 32'(cnt3), 32'd3);

      // freeze for two cycles in the middle of the stall
      resetAll();
      applyStimulus(5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("fz_c1_bubble", 32'(bubble3), 32'd1);
      for (int c = 2; c <= 3; c++) begin
         applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput($sformatf("fz_c%0d_freeze", c), 32'(frz3), 32'd1);
         checkOutput($sformatf("fz_c%0d_pc", c), 32'(pc3), 32'd0);
         checkOutput($sformatf("fz_c%0d_bubble", c), 32'(bubble3), 32'd0);
      end
      for (int c = 4; c <= 5; c++) begin
         idleCycle();
         checkOutput($sformatf("fz_c%0d_bubble", c), 32'(bubble3), 32'd1);
         checkOutput($sformatf("fz_c%0d_freeze", c), 32'(frz3), 32'd0);
      end
      idleCycle();
      checkOutput("fz_done_pc", 32'(pc3), 32'd1);
      checkOutput("fz_cnt", 32'(cnt3), 32'd5);

      // false hazards: x0 destination, match only on an unused field
      resetAll();
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("x0_pc", 32'(pc3), 32'd1);
      applyStimulus(5'd9, 5'd9, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("unused_pc", 32'(pc3), 32'd1);
      checkOutput("unused_bubble", 32'(bubble3), 32'd0);
      idleCycle();
      checkOutput("false_cnt", 32'(cnt3), 32'd0);

      // hazard and branch together: flush wins
      applyStimulus(5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("brhz_flush", 32'(flush3), 32'd1);
      checkOutput("brhz_bubble", 32'(bubble3), 32'd1);
      checkOutput("brhz_pc", 32'(pc3), 32'd1);
      checkOutput("brhz_busy", 32'(busy3), 32'd0);
      idleCycle();
      checkOutput("brhz_after_busy", 32'(busy3), 32'd0);
      checkOutput("brhz_cnt", 32'(cnt3), 32'd0);

      // branch while in LWAIT cancels the remaining stall
      applyStimulus(5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("brlw_flush", 32'(flush3), 32'd1);
      checkOutput("brlw_busy", 32'(busy3), 32'd1);
      idleCycle();
      checkOutput("brlw_after_busy", 32'(busy3), 32'd0);
      checkOutput("brlw_after_pc", 32'(pc3), 32'd1);
      checkOutput("brlw_cnt", 32'(cnt3), 32'd1);

      // branch held under a freeze flushes on the first unfrozen cycle
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("brfz_flush", 32'(flush3), 32'd0);
      checkOutput("brfz_freeze", 32'(frz3), 32'd1);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("brfz_late_flush", 32'(flush3), 32'd1);

      // counter saturation on the narrow instance
      resetAll();
      for (int c = 0; c < 20; c++)
         applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idleCycle();
      checkOutput("sat_cnt4", 32'(cnt4), 32'd15);
      checkOutput("wide_cnt3", 32'(cnt3), 32'd20);
      idleCycle();
      checkOutput("sat_cnt4_hold", 32'(cnt4), 32'd15);

      // asynchronous reset in the middle of LWAIT with the hazard still driven
      applyStimulus(5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rstmid_busy_before", 32'(busy3), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid_pc", 32'(pc3), 32'd1);
      checkOutput("rstmid_ifid", 32'(ifid3), 32'd1);
      checkOutput("rstmid_bubble", 32'(bubble3), 32'd0);
      checkOutput("rstmid_busy", 32'(busy3), 32'd0);
      checkOutput("rstmid_cnt", 32'(cnt3), 32'd0);
      exRd = '0; idRs1 = '0; idRs1Used = 1'b0; exMemRead = 1'b0;
      #2;
      rst_n = 1'b1;
      idleCycle();
      checkOutput("rstrel_pc", 32'(pc3), 32'd1);
      checkOutput("rstrel_busy", 32'(busy3), 32'd0);
      checkOutput("rstrel_cnt", 32'(cnt3), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
